// File: rtl/riscv_pkg.sv
// riscv_pkg: shared ALU opcodes, shifter FSM state type and latency helper.
package riscv_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} slli_state_t;
  localparam logic [3:0] ALU_SLL = 4'b1001;
  localparam logic [3:0] ALU_SRL = 4'b1010;
  function automatic int slli_latency(input int shamt, input int step);
    return 1 + (shamt + step - 1) / step;
  endfunction
endpackage

// File: rtl/sll_step.sv
// sll_step: zero-fill left shift of operand by k bits (k bounded by STEP upstream).
module sll_step #(
  parameter int DATA_WIDTH = 32,
  parameter int KW = 6
) (
  input  logic [DATA_WIDTH-1:0] operand_i,
  input  logic [KW-1:0]         k_i,
  output logic [DATA_WIDTH-1:0] result_o
);
  assign result_o = operand_i << k_i;
endmodule

// File: rtl/slli_seq_unit.sv
// slli_seq_unit: multi-cycle SLL/SLLI, shifts at most STEP bits per clock behind valid/ready.
module slli_seq_unit
  import riscv_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int SHAMT_WIDTH = 5,
  parameter int STEP        = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] SrcA,
  input  logic [DATA_WIDTH-1:0] Immediate,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] Rd,
  output logic                  busy
);
  // one extra bit so STEP == DATA_WIDTH is representable in the step count
  localparam int RW = SHAMT_WIDTH + 1;
  localparam logic [RW-1:0] STEP_R = RW'(STEP);
  slli_state_t state_q, state_d;
  logic [DATA_WIDTH-1:0] rd_q, rd_d, shifted;
  logic [RW-1:0] rem_q, rem_d, k, rem_left;
  logic [SHAMT_WIDTH-1:0] shamt;
  sll_step #(.DATA_WIDTH(DATA_WIDTH), .KW(RW)) u_step (
    .operand_i(rd_q),
    .k_i(k),
    .result_o(shifted)
  );
  assign shamt = Immediate[SHAMT_WIDTH-1:0];
  assign k = rem_q < STEP_R ? rem_q : STEP_R;
  assign rem_left = rem_q - k;
  assign in_ready = state_q == IDLE && !reset;
  assign out_valid = state_q == DONE;
  assign busy = state_q != IDLE;
  assign Rd = rd_q;
  always_comb begin
    state_d = state_q;
    rd_d = rd_q;
    rem_d = rem_q;
    if (flush) state_d = IDLE;
    else
      case (state_q)
        IDLE: if (in_valid) begin
          rd_d = SrcA;
          rem_d = {1'b0, shamt};
          state_d = shamt == '0 ? DONE : SHIFT;
        end
        SHIFT: begin
          rd_d = shifted;
          rem_d = rem_left;
          state_d = rem_left == '0 ? DONE : SHIFT;
        end
        DONE: state_d = out_ready ? IDLE : DONE;
        default: state_d = IDLE;
      endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      rd_q <= '0;
      rem_q <= '0;
    end else begin
      state_q <= state_d;
      rd_q <= rd_d;
      rem_q <= rem_d;
    end
  end
endmodule

// File: tb/tb_slli_seq_unit.sv
// tb_slli_seq_unit: vector table plus corner sequences on STEP=1 and STEP=4 instances.
module tb_slli_seq_unit;
  logic clk = 1'b0;
  logic reset, flush;
  logic in_valid[2], in_ready[2], out_valid[2], out_ready[2], busy[2];
  logic [31:0] srca[2], imm[2], rd[2];
  int total = 0, bad = 0;
  typedef struct {logic [31:0] rd; int lat;} exp_t;
  typedef struct {int u; logic [31:0] a; logic [31:0] i; logic [31:0] rd;} vec_t;
  exp_t sb[$];
  vec_t vecs[8];
  int steps[2] = '{1, 4};
  always #5 clk = ~clk;
  slli_seq_unit #(.STEP(1)) dut1 (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .SrcA(srca[0]), .Immediate(imm[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .Rd(rd[0]), .busy(busy[0])
  );
  slli_seq_unit #(.STEP(4)) dut4 (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .SrcA(srca[1]), .Immediate(imm[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .Rd(rd[1]), .busy(busy[1])
  );
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask
  task automatic drive(input int u, input logic [31:0] a, input logic [31:0] i);
    in_valid[u] = 1'b1;
    srca[u] = a;
    imm[u] = i;
    chk("accept in_ready", {31'b0, in_ready[u]}, 32'd1);
    tick;
    in_valid[u] = 1'b0;
    srca[u] = $urandom;
    imm[u] = $urandom;
  endtask
  task automatic accept(input int u, input logic [31:0] a, input logic [31:0] i);
    exp_t e;
    int sh;
    sh = int'(i[4:0]);
    e.rd = a << i[4:0];
    e.lat = 1 + (sh + steps[u] - 1) / steps[u];
    drive(u, a, i);
    sb.push_back(e);
  endtask
  task automatic wait_out(input int u, input int c0, input string name);
    exp_t e;
    int c;
    c = c0;
    while (!out_valid[u] && c < 200) begin
      chk({name, " busy"}, {31'b0, busy[u]}, 32'd1);
      tick;
      c++;
    end
    e = sb.pop_front();
    if (!out_valid[u]) begin
      total++;
      bad++;
      $display("FAIL %s timeout: out_valid=0 after %0d cycles, want cycle %0d", name, c, e.lat);
    end else begin
      chk({name, " rd"}, rd[u], e.rd);
      chk({name, " lat"}, 32'(c), 32'(e.lat));
      chk({name, " busy@done"}, {31'b0, busy[u]}, 32'd1);
    end
  endtask
  task automatic run(input int u, input logic [31:0] a, input logic [31:0] i, input string name);
    accept(u, a, i);
    wait_out(u, 1, name);
    tick;
    chk({name, " in_ready after"}, {31'b0, in_ready[u]}, 32'd1);
    chk({name, " out_valid after"}, {31'b0, out_valid[u]}, 32'd0);
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    logic [31:0] held;
    logic seen;
    vecs[0] = '{0, 32'h0000_0001, 32'd5, 32'h0000_0020};
    vecs[1] = '{0, 32'hDEAD_BEEF, 32'h0000_0020, 32'hDEAD_BEEF};
    vecs[2] = '{0, 32'hFFFF_FFFF, 32'd31, 32'h8000_0000};
    vecs[3] = '{1, 32'h0000_00F1, 32'd9, 32'h0001_E200};
    vecs[4] = '{1, 32'h8000_0001, 32'd3, 32'h0000_0008};
    vecs[5] = '{1, 32'h1234_5678, 32'd0, 32'h1234_5678};
    vecs[6] = '{1, 32'hFFFF_FFFF, 32'd31, 32'h8000_0000};
    vecs[7] = '{0, 32'hA5A5_A5A5, 32'hFFFF_FFE4, 32'h5A5A_5A50};
    reset = 1'b1;
    flush = 1'b0;
    for (int u = 0; u < 2; u++) begin
      in_valid[u] = 1'b0;
      out_ready[u] = 1'b1;
      srca[u] = '0;
      imm[u] = '0;
    end
    repeat (3) tick;
    for (int u = 0; u < 2; u++) begin
      chk("reset in_ready", {31'b0, in_ready[u]}, 32'd0);
      chk("reset rd", rd[u], 32'd0);
      chk("reset out_valid", {31'b0, out_valid[u]}, 32'd0);
      chk("reset busy", {31'b0, busy[u]}, 32'd0);
    end
    reset = 1'b0;
    tick;
    chk("post-reset in_ready", {31'b0, in_ready[0]}, 32'd1);
    for (int v = 0; v < 8; v++) begin
      chk("table expect model", vecs[v].a << vecs[v].i[4:0], vecs[v].rd);
      run(vecs[v].u, vecs[v].a, vecs[v].i, $sformatf("vec%0d", v));
    end
    for (int r = 0; r < 6; r++) run(r % 2, $urandom, $urandom, $sformatf("rand%0d", r));
    // backpressure, with a new operand queued during the stall
    out_ready[0] = 1'b0;
    accept(0, 32'd3, 32'd2);
    wait_out(0, 1, "bp");
    held = rd[0];
    in_valid[0] = 1'b1;
    srca[0] = 32'd7;
    imm[0] = 32'd4;
    repeat (5) begin
      tick;
      chk("bp rd held", rd[0], held);
      chk("bp out_valid held", {31'b0, out_valid[0]}, 32'd1);
      chk("bp in_ready low", {31'b0, in_ready[0]}, 32'd0);
    end
    out_ready[0] = 1'b1;
    tick;
    chk("bp handoff out_valid", {31'b0, out_valid[0]}, 32'd0);
    chk("bp handoff in_ready", {31'b0, in_ready[0]}, 32'd1);
    sb.push_back('{32'h0000_0070, 5});
    tick;
    in_valid[0] = 1'b0;
    wait_out(0, 1, "queued");
    tick;
    // flush mid-shift
    drive(0, 32'd5, 32'd20);
    repeat (6) tick;
    flush = 1'b1;
    in_valid[0] = 1'b1;
    srca[0] = 32'hFFFF;
    imm[0] = 32'd1;
    tick;
    flush = 1'b0;
    in_valid[0] = 1'b0;
    chk("flush busy", {31'b0, busy[0]}, 32'd0);
    chk("flush out_valid", {31'b0, out_valid[0]}, 32'd0);
    chk("flush in_ready", {31'b0, in_ready[0]}, 32'd1);
    seen = 1'b0;
    repeat (30) begin
      tick;
      seen |= out_valid[0] | busy[0];
    end
    chk("flush no result", {31'b0, seen}, 32'd0);
    // reset mid-shift
    drive(0, 32'd5, 32'd20);
    repeat (6) tick;
    reset = 1'b1;
    #1;
    chk("rst7 in_ready", {31'b0, in_ready[0]}, 32'd0);
    tick;
    reset = 1'b0;
    #1;
    chk("rst8 rd", rd[0], 32'd0);
    chk("rst8 busy", {31'b0, busy[0]}, 32'd0);
    chk("rst8 out_valid", {31'b0, out_valid[0]}, 32'd0);
    chk("rst8 in_ready", {31'b0, in_ready[0]}, 32'd1);
    // in_valid pulsed while shifting must not be latched
    accept(0, 32'd1, 32'd10);
    tick;
    tick;
    in_valid[0] = 1'b1;
    srca[0] = 32'h1234;
    imm[0] = 32'd1;
    tick;
    in_valid[0] = 1'b0;
    wait_out(0, 4, "ignored");
    tick;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/slli_seq_unit.md
Name: slli_seq_unit

Overview:
Multi-cycle shift-left-logical unit for SLLI/SLL. It performs the opposite-direction counterpart of the right-shift path. The operand is shifted left by at most STEP bits per clock under an FSM, so the EX stage carries no full barrel shifter. Operands arrive and results leave through valid/ready handshakes, and the hazard unit uses busy to stall the pipeline.

Parameters:
- DATA_WIDTH, 32, operand/result width.
- SHAMT_WIDTH, 5, shift-amount bits taken from Immediate[SHAMT_WIDTH-1:0]; must equal log2(DATA_WIDTH).
- STEP, 1, maximum bits shifted per cycle; power of two, 1..DATA_WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- flush  input  1  synchronous kill of the in-flight operation (branch mispredict).
- in_valid  input  1  SrcA/Immediate valid.
- in_ready  output  1  unit can accept an operand.
- SrcA  input  DATA_WIDTH  rs1 value.
- Immediate  input  DATA_WIDTH  immediate or rs2; only the low SHAMT_WIDTH bits are used.
- out_valid  output  1  Rd holds the final result.
- out_ready  input  1  consumer takes the result.
- Rd  output  DATA_WIDTH  shifted result.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- Reset: state=IDLE, Rd=0, out_valid=0, busy=0, remaining count=0. in_ready is 0 while reset is high and 1 in the first cycle after reset.
- FSM states: IDLE, SHIFT, DONE.
  - in_ready = (state==IDLE) && !reset.
  - out_valid = (state==DONE).
- Accept: at an edge where in_valid && in_ready, latch Rd<=SrcA and rem<=Immediate[SHAMT_WIDTH-1:0].
  - rem==0: go to DONE.
  - otherwise: go to SHIFT.
- SHIFT, each edge:
  - k = min(STEP, rem); Rd <= Rd << k (zero fill); rem <= rem - k.
  - If rem - k == 0, go to DONE on that same edge.
- DONE:
  - Rd holds stable while out_valid && !out_ready (backpressure; no change while stalled).
  - On out_valid && out_ready, go to IDLE.
  - There is no accept in the handoff cycle; in_ready rises the following cycle.
- Latency: accept in cycle 0, out_valid asserted in cycle 1 + ceil(shamt/STEP). shamt=0 gives out_valid in cycle 1.
- Width rule: a shift amount of DATA_WIDTH-1 with STEP=1 is the worst case, 32 cycles to out_valid. All bits shifted past the MSB are discarded, and the result is never sign-extended.
- flush: has priority over all handshakes except reset. On the next edge, state goes to IDLE, out_valid goes to 0, and Rd is left unchanged (don't-care). in_valid is ignored in the flush cycle.
- reset vs flush: reset wins, and all reset values apply.
- Reset or flush mid-SHIFT discards the operation; no partial result is ever presented with out_valid=1.
- in_valid while busy: ignored, and the operand is not latched. The producer holds it until in_ready.
- Inputs are sampled only at the accept edge; later changes to SrcA/Immediate have no effect.

Decomposition:
- Shared package riscv_pkg:
  - state enum slli_state_t {IDLE, SHIFT, DONE}.
  - ALU opcode constants ALU_SLL=4'b1001 and ALU_SRL=4'b1010, shared with the existing ALU decode.
  - Localparam helper for ceil-latency used by the testbench.
- Sub-module sll_step:
  - Combinational; inputs operand and k (0..STEP); output operand << k.
  - Instantiated once; keeps the FSM file free of shift datapath.

Test Plan:
- Basic shift: STEP=1, SrcA=0x0000_0001, Immediate=5, out_ready=1 → out_valid in cycle 6, Rd=0x0000_0020, busy high cycles 1-6, in_ready high again cycle 7.
- Zero shift and Immediate masking: Immediate=0x0000_0020 (shamt field=0), SrcA=0xDEAD_BEEF → out_valid in cycle 1, Rd=0xDEAD_BEEF. Then Immediate=31, SrcA=0xFFFF_FFFF → Rd=0x8000_0000 in cycle 32.
- STEP=4 uneven: SrcA=0x0000_00F1, Immediate=9 → out_valid in cycle 4 (shifts 4,4,1), Rd=0x0001_E200.
- Backpressure: out_ready=0 for 5 cycles after out_valid → Rd and out_valid held stable and in_ready=0 throughout. out_ready=1 → IDLE next cycle, and a queued in_valid is accepted the cycle after.
- Flush/reset mid-shift: shamt=20, flush asserted in cycle 7 → IDLE in cycle 8 and out_valid never asserted. Repeat with reset in cycle 7 → Rd=0, in_ready=0 in cycle 7 and 1 in cycle 8.
- Ignored input: in_valid pulsed with SrcA=0x1234 in cycle 3 while SHIFT → no latch; final Rd matches the original operand only.
